// File: rtl/uart_word_tx.sv
// Buffered UART transmitter: words queue in a FIFO and go out MSB byte first, back-to-back frames.
// Optional even parity bit per frame when UART_TX_PARITY_EN is defined.
module uart_word_tx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int WORD_BYTES   = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [8*WORD_BYTES-1:0]       in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DW = 8 * WORD_BYTES;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(WORD_BYTES - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [BW-1:0] byte_idx_q, byte_idx_d;
  logic          stop_idx_q, stop_idx_d;
  logic [DW-1:0] word_q, word_d;
  logic [7:0]    cur_byte_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          push, pop;
  logic [DW-1:0] head;

  assign in_ready   = (count_q != FIFO_FULL);
  assign push       = in_valid && in_ready;
  assign head       = mem[rd_ptr_q];
  assign bit_end    = (clk_cnt_q == CNT_LAST);
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;
  assign uart_tx    = tx_q;

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    stop_idx_d = stop_idx_q;
    word_d     = word_q;
    pop        = 1'b0;
    clk_cnt_d  = (state_q == S_IDLE || bit_end) ? '0 : clk_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          word_d     = head;
          byte_idx_d = '0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            stop_idx_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            state_d    = S_PARITY;
`else
            state_d    = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          stop_idx_d = 1'b0;
          state_d    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_q != STOP_LAST) begin
            stop_idx_d = 1'b1;
          end else if (byte_idx_q != BYTE_LAST) begin
            byte_idx_d = byte_idx_q + 1'b1;
            word_d     = word_q << 8;
            state_d    = S_START;
          end else if (count_q != '0) begin
            // Chain straight into the next word so frames stay gap-free.
            pop        = 1'b1;
            word_d     = head;
            byte_idx_d = '0;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is registered from the next-state decode so the pin never glitches.
  always_comb begin
    cur_byte_d = word_d[DW-1 -: 8];
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = cur_byte_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^cur_byte_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      stop_idx_q <= 1'b0;
      word_q     <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      stop_idx_q <= stop_idx_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: per-cycle line model plus table vectors and corner sequences.
module tb_uart_word_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FB       = 10 + P;
  localparam int WORD_LEN = 4 * FB * CPB;
  localparam int LEN2     = (FB + 1) * CPB;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready, uart_tx, busy;
  logic [2:0]  fifo_count;

  logic [7:0]  in_data2;
  logic        in_valid2;
  logic        in_ready2, uart_tx2, busy2;
  logic [2:0]  fifo_count2;

  always #5 clk = ~clk;

  uart_word_tx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(4), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .uart_tx(uart_tx), .busy(busy), .fifo_count(fifo_count)
  );

  uart_word_tx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(1), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .uart_tx(uart_tx2), .busy(busy2), .fifo_count(fifo_count2)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  par;   // even parity of bytes 0..3, byte 0 in bit 3
  } vec_t;

  bit   line_q[$];
  bit   first_q[$];
  int   mcount;
  int   n_pass, n_checks, n_fail;
  logic acc_last;
  logic s_tx [0:199];
  logic s_busy [0:199];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected line samples for one word, one entry per clock cycle.
  task automatic append_word(input logic [31:0] w);
    logic [31:0] sh;
    logic [7:0]  b8;
    bit          fb[$];
    for (int b = 0; b < 4; b++) begin
      sh = w >> (8 * (3 - b));
      b8 = sh[7:0];
      fb.delete();
      fb.push_back(1'b0);
      for (int i = 0; i < 8; i++) fb.push_back(b8[i]);
`ifdef UART_TX_PARITY_EN
      fb.push_back(^b8);
`endif
      fb.push_back(1'b1);
      foreach (fb[j]) begin
        for (int r = 0; r < CPB; r++) begin
          line_q.push_back(fb[j]);
          first_q.push_back(b == 0 && j == 0 && r == 0);
        end
      end
    end
  endtask

  task automatic step();
    logic        acc;
    logic [31:0] d;
    bit          exp_tx, first, active;
    acc = in_valid && (mcount != DEPTH);
    d   = in_data;
    @(posedge clk);
    #1;
    if (line_q.size() > 0) begin
      exp_tx = line_q.pop_front();
      first  = first_q.pop_front();
      active = 1'b1;
    end else begin
      exp_tx = 1'b1;
      first  = 1'b0;
      active = 1'b0;
    end
    if (first) mcount--;
    if (acc) begin
      mcount++;
      append_word(d);
    end
    acc_last = acc;
    check("tx", uart_tx, exp_tx);
    check("fifo_count", fifo_count, mcount);
    check("in_ready", in_ready, mcount != DEPTH);
    check("busy", busy, active || mcount != 0);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((line_q.size() != 0 || mcount != 0) && n < bound) begin
      step();
      n++;
    end
    check("wait_idle_bound", line_q.size() + mcount, 0);
    step();
  endtask

  initial begin
    vec_t        vecs [5];
    logic [31:0] w, sh;
    logic [7:0]  b8;
    logic        e;
    logic [11:0] exp55;
    int          n_acc, edges, peak, target;

    vecs[0] = '{32'hF9B99B9F, 4'b0110};
    vecs[1] = '{32'h00000000, 4'b0000};
    vecs[2] = '{32'hFFFFFFFF, 4'b0000};
    vecs[3] = '{32'h01020304, 4'b1101};
    vecs[4] = '{32'h80FF7F01, 4'b1011};
`ifdef UART_TX_PARITY_EN
    exp55 = 12'b1100_1010_1010;
`else
    exp55 = 12'b0110_1010_1010;
`endif

    n_pass = 0; n_checks = 0; n_fail = 0; mcount = 0; acc_last = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_valid2 = 1'b0; in_data2 = '0;
    #12;
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", in_ready, 1);
    check("rst_tx2", uart_tx2, 1);
    check("rst_busy2", busy2, 0);
    @(negedge clk) reset_n = 1'b1;

    for (int i = 0; i < 100; i++) step();

    // Table vectors: one word at a time from idle, line sampled mid-bit.
    for (int v = 0; v < 5; v++) begin
      wait_idle(3000);
      w = vecs[v].data;
      in_data = w; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("tbl_accept", acc_last, 1);
      in_data = ~w;
      for (int k = 1; k <= WORD_LEN + 1; k++) begin
        step();
        s_tx[k] = uart_tx;
        s_busy[k] = busy;
      end
      check("tbl_latency", s_tx[1], 0);
      for (int b = 0; b < 4; b++) begin
        sh = w >> (8 * (3 - b));
        b8 = sh[7:0];
        for (int j = 0; j < FB; j++) begin
          if (j == 0) e = 1'b0;
          else if (j <= 8) e = b8[j-1];
`ifdef UART_TX_PARITY_EN
          else if (j == 9) e = vecs[v].par[3-b];
`endif
          else e = 1'b1;
          check("tbl_bit", s_tx[1 + (b * FB + j) * CPB + CPB / 2], e);
        end
      end
      check("tbl_busy_last", s_busy[WORD_LEN], 1);
      check("tbl_busy_end", s_busy[WORD_LEN + 1], 0);
    end

    // Five pushes on consecutive cycles from idle.
    wait_idle(3000);
    n_acc = 0; edges = 0; peak = 0;
    in_valid = 1'b1; in_data = $urandom;
    while (n_acc < 5 && edges < 100) begin
      step();
      edges++;
      if (acc_last) begin
        n_acc++;
        in_data = $urandom;
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    in_valid = 1'b0;
    check("burst_accepted", n_acc, 5);
    check("burst_edges", edges, 5);
    check("burst_peak", peak, 4);
    for (int i = 0; i < 40; i++) begin
      step();
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    check("burst_peak_hold", peak, 4);
    wait_idle(6000);

    // Random traffic with backpressure.
    for (int i = 0; i < 900; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = $urandom;
      step();
    end
    in_valid = 1'b0;
    wait_idle(6000);
    check("drain_busy", busy, 0);

    // Single byte, two stop bits, on the second instance.
    in_data2 = 8'h55; in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    in_data2 = 8'hAA;
    for (int k = 1; k <= LEN2 + 1; k++) begin
      step();
      s_tx[k] = uart_tx2;
      s_busy[k] = busy2;
    end
    check("b55_latency", s_tx[1], 0);
    for (int j = 0; j < FB + 1; j++) check("b55_bit", s_tx[1 + j * CPB + CPB / 2], exp55[j]);
    check("b55_busy_last", s_busy[LEN2], 1);
    check("b55_busy_end", s_busy[LEN2 + 1], 0);

    // Reset during DATA of byte 2 with two words still queued.
    wait_idle(3000);
    n_acc = 0; edges = 0;
    in_valid = 1'b1; in_data = $urandom;
    while (n_acc < 3 && edges < 20) begin
      step();
      edges++;
      if (acc_last) begin
        n_acc++;
        in_data = $urandom;
      end
    end
    in_valid = 1'b0;
    check("rst_mid_pushes", n_acc, 3);
    target = 2 * FB * CPB + CPB + 6;
    for (int k = 2; k < target; k++) step();
    check("rst_mid_queued", fifo_count, 2);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_tx", uart_tx, 1);
    check("rst_mid_count", fifo_count, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", in_ready, 1);
    line_q.delete();
    first_q.delete();
    mcount = 0;
    @(negedge clk) reset_n = 1'b1;
    for (int i = 0; i < 60; i++) step();
    check("post_rst_tx", uart_tx, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
